// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and round-robin search helper for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {IDLE, BURST} arb_state_e;

  // One-hot grant for the first set bit of req above last, wrapping modulo num.
  function automatic logic [MAX_REQ-1:0] rr_next(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last,
    input logic [IDX_W:0]     num
  );
    logic [MAX_REQ-1:0] gnt;
    logic [IDX_W:0]     idx;
    gnt = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = {1'b0, last} + (IDX_W+1)'(k);
      if (idx >= num) idx = idx - num;
      if (((IDX_W+1)'(k) <= num) && req[idx[IDX_W-1:0]]) begin
        gnt = '0;
        gnt[idx[IDX_W-1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: request vector and last owner in, one-hot grant and index out.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [MAX_REQ-1:0] gnt_full;
  logic               unused_gnt_hi;

  assign gnt_full      = rr_next(MAX_REQ'(req), IDX_W'(last_idx), (IDX_W+1)'(N));
  assign gnt           = gnt_full[N-1:0];
  assign unused_gnt_hi = ^gnt_full;
  assign any           = |req;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst-locking write arbiter in front of a synchronous FIFO.
// Optional per-requester beat and stall counters are built when FIFO_WR_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters, no beat accepted
// BURST | owner holds the FIFO port until req_last or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wen,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic [NUM_REQ-1:0]         grant,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0]  beat_count,
  output logic [STAT_W-1:0]          stall_cycles,
`endif
  output logic                       busy
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               accept;
  logic [CNT_W-1:0]   cnt_next;
  logic               done;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req      (req_valid),
    .last_idx (last_grant_q),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .any      (pick_any)
  );

  // Handshake and write path are combinational so a beat lands in the same cycle it is accepted.
  always_comb begin
    req_ready    = '0;
    fifo_wen     = 1'b0;
    fifo_data_in = '0;
    accept       = 1'b0;
    if (!rst && state_q == BURST) begin
      req_ready[owner_q] = !fifo_full;
      accept             = req_valid[owner_q] && !fifo_full;
      fifo_wen           = accept;
      if (accept) fifo_data_in = req_data[owner_q*WIDTH +: WIDTH];
    end
  end

  assign cnt_next = beat_cnt_q + CNT_W'(1);
  assign done     = accept && (req_last[owner_q] || cnt_next == CNT_W'(MAX_BURST));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_gnt;
          owner_d = pick_idx;
          busy_d  = 1'b1;
        end
      end
      BURST: begin
        if (done) begin
          state_d      = IDLE;
          grant_d      = '0;
          beat_cnt_d   = '0;
          last_grant_d = owner_q;
          busy_d       = 1'b0;
        end else if (accept) begin
          beat_cnt_d = cnt_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*STAT_W-1:0] beat_count_q, beat_count_d;
  logic [STAT_W-1:0]         stall_q, stall_d;

  always_comb begin
    beat_count_d = beat_count_q;
    stall_d      = stall_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && owner_q == IW'(i) && beat_count_q[i*STAT_W +: STAT_W] != '1)
        beat_count_d[i*STAT_W +: STAT_W] = beat_count_q[i*STAT_W +: STAT_W] + STAT_W'(1);
    end
    if (state_q == BURST && fifo_full && stall_q != '1) stall_d = stall_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count_q <= '0;
      stall_q      <= '0;
    end else begin
      beat_count_q <= beat_count_d;
      stall_q      <= stall_d;
    end
  end

  assign beat_count   = beat_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=8).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_last, req_ready, grant;
  logic [NR*W-1:0]   req_data;
  logic              fifo_full, fifo_wen, busy;
  logic [W-1:0]      fifo_data_in;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0]  beat_count;
  logic [15:0]       stall_cycles;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wen     (fifo_wen),
    .fifo_data_in (fifo_data_in),
    .grant        (grant),
`ifdef FIFO_WR_ARB_STATS_EN
    .beat_count   (beat_count),
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [W-1:0] v);
    req_data[r*W +: W] = v;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_wen"},   32'(fifo_wen), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_data"},  32'(fifo_data_in), 32'h0);
  endtask

  task automatic expect_beat(input string tag, input int r, input logic [W-1:0] d);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    chk({tag, "_grant"}, 32'(grant), 32'(oh));
    chk({tag, "_busy"},  32'(busy), 32'h1);
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    chk({tag, "_wen"},   32'(fifo_wen), 32'h1);
    chk({tag, "_data"},  32'(fifo_data_in), 32'(d));
  endtask

  task automatic expect_stall(input string tag, input int r);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    chk({tag, "_grant"}, 32'(grant), 32'(oh));
    chk({tag, "_busy"},  32'(busy), 32'h1);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_wen"},   32'(fifo_wen), 32'h0);
    chk({tag, "_data"},  32'(fifo_data_in), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Single requester, 3-beat burst, then last_grant=0 makes req1 win over req0.
    do_reset();
    #1 expect_idle("rst");
    req_valid = 4'b0001;
    set_data(0, 8'hA1);
    #1 expect_idle("s1_arb");
    tick(); #1 expect_beat("s1_b0", 0, 8'hA1);
    tick(); set_data(0, 8'hA2); #1 expect_beat("s1_b1", 0, 8'hA2);
    tick(); set_data(0, 8'hA3); req_last = 4'b0001; #1 expect_beat("s1_b2", 0, 8'hA3);
    tick(); req_valid = '0; req_last = '0; #1 expect_idle("s1_done");
    req_valid = 4'b0011; req_last = 4'b0011; set_data(1, 8'hB1);
    #1 expect_idle("s1_arb2");
    tick(); #1 expect_beat("s1_lastg", 1, 8'hB1);
    tick(); req_valid = '0; req_last = '0; #1 expect_idle("s1_done2");

    // All requesters valid, 1-beat bursts: order 0,1,2,3,0,... with an IDLE between.
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, W'(8'h10 + i));
    for (int b = 0; b < 8; b++) begin
      #1 expect_idle($sformatf("s2_idle%0d", b));
      tick();
      #1 expect_beat($sformatf("s2_b%0d", b), b % NR, W'(8'h10 + (b % NR)));
      tick();
    end
    req_valid = '0;
    req_last  = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk($sformatf("s2_cnt%0d", i), 32'(beat_count[i*16 +: 16]), 32'd2);
    chk("s2_stall", 32'(stall_cycles), 32'd0);
`endif

    // Requester 2 streams without last: forced release at 8, regrant, then req3 wins.
    do_reset();
    req_valid = 4'b0100;
    set_data(2, 8'h30);
    #1 expect_idle("s3_arb");
    tick();
    for (int n = 0; n < 8; n++) begin
      set_data(2, W'(8'h30 + n));
      #1 expect_beat($sformatf("s3_a%0d", n), 2, W'(8'h30 + n));
      tick();
    end
    #1 expect_idle("s3_forced");
    tick();
    for (int n = 8; n < 12; n++) begin
      set_data(2, W'(8'h30 + n));
      #1 expect_beat($sformatf("s3_b%0d", n), 2, W'(8'h30 + n));
      tick();
    end
    req_valid = 4'b0000;
    for (int g = 0; g < 2; g++) begin
      #1;
      chk($sformatf("s3_gap%0d_grant", g), 32'(grant), 32'h4);
      chk($sformatf("s3_gap%0d_ready", g), 32'(req_ready), 32'h4);
      chk($sformatf("s3_gap%0d_wen", g), 32'(fifo_wen), 32'h0);
      tick();
    end
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    set_data(3, 8'hC3);
    for (int n = 12; n < 16; n++) begin
      set_data(2, W'(8'h30 + n));
      #1 expect_beat($sformatf("s3_c%0d", n), 2, W'(8'h30 + n));
      tick();
    end
    #1 expect_idle("s3_forced2");
    tick();
    #1 expect_beat("s3_next", 3, 8'hC3);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1 expect_idle("s3_done");

    // FIFO full for 3 cycles after beat 2; count must hold so release still lands after beat 8.
    do_reset();
    req_valid = 4'b0001;
    set_data(0, 8'h50);
    #1 expect_idle("s4_arb");
    tick();
    for (int n = 0; n < 8; n++) begin
      set_data(0, W'(8'h50 + n));
      if (n == 2) begin
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1 expect_stall($sformatf("s4_full%0d", s), 0);
          tick();
        end
        fifo_full = 1'b0;
      end
      #1 expect_beat($sformatf("s4_b%0d", n), 0, W'(8'h50 + n));
      tick();
    end
    req_valid = '0;
    #1 expect_idle("s4_done");

    // Reset in the 2nd beat of a req1 burst, then all-valid arbitration picks req0.
    do_reset();
    req_valid = 4'b0010;
    set_data(1, 8'h61);
    #1 expect_idle("s5_arb");
    tick(); #1 expect_beat("s5_b0", 1, 8'h61);
    tick();
    set_data(1, 8'h62);
    rst = 1'b1;
    #1;
    chk("s5_rst_wen", 32'(fifo_wen), 32'h0);
    chk("s5_rst_ready", 32'(req_ready), 32'h0);
    chk("s5_rst_data", 32'(fifo_data_in), 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    set_data(0, 8'h70);
    #1 expect_idle("s5_post");
    tick(); #1 expect_beat("s5_first", 0, 8'h70);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1 expect_idle("s5_done");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
